mult_err_accum: RTL and testbench

MULT_ERR_ACCUM -- requirements
Module: mult_err_accum

---
 rtl/mult_err_accum.sv | 150 +++++++++++++++
 tb/tb_mult_err_accum.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_err_accum.sv
// Mantissa-error and sign/exponent-mismatch accumulator for three approximate float multipliers,
// measured over a fixed window of counted samples against a precise reference product.
module mult_err_accum #(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned ACC_W    = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                exc,
  input  logic [31:0]         result,
  input  logic [31:0]         result_approx,
  input  logic [31:0]         result_drum,
  input  logic [31:0]         result_foil,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    err_approx,
  output logic [ACC_W-1:0]    err_drum,
  output logic [ACC_W-1:0]    err_foil,
  output logic [WIN_LOG2:0]   mism_approx,
  output logic [WIN_LOG2:0]   mism_drum,
  output logic [WIN_LOG2:0]   mism_foil
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [WIN_LOG2:0] LastCnt = {1'b0, {WIN_LOG2{1'b1}}};

  state_e                  state_q, state_d;
  logic                    drain_q, drain_d;
  logic [WIN_LOG2:0]       cnt_q;
  logic                    hs, hs_cnt, clear;
  logic [2:0][31:0]        dut_res;
  logic [2:0][23:0]        m_err, s1_err_q;
  logic [2:0]              m_mism, s1_mism_q;
  logic                    s1_valid_q;
  logic [2:0][ACC_W:0]     acc_sum;
  logic [2:0][ACC_W-1:0]   acc_q, acc_d;
  logic [2:0][WIN_LOG2:0]  mism_q, mism_d;

  // Returns {mismatch, error}; a sign or exponent difference scores the worst-case error.
  function automatic logic [24:0] metric(input logic [31:0] ref_v, input logic [31:0] x);
    logic [23:0] a, b;
    logic [24:0] r;
    a = {1'b1, ref_v[22:0]};
    b = {1'b1, x[22:0]};
    if (ref_v[31:23] != x[31:23]) r = {1'b1, 24'hFFFFFF};
    else if (a >= b)              r = {1'b0, a - b};
    else                          r = {1'b0, b - a};
    return r;
  endfunction

  assign hs      = in_valid & in_ready;
  assign hs_cnt  = hs & ~exc;
  assign clear   = start & ((state_q == StIdle) | (state_q == StDone));
  assign dut_res = {result_foil, result_drum, result_approx};

  always_comb begin
    m_err   = '0;
    m_mism  = '0;
    acc_sum = '0;
    acc_d   = '0;
    mism_d  = '0;
    for (int i = 0; i < 3; i++) begin
      {m_mism[i], m_err[i]} = metric(result, dut_res[i]);
      acc_sum[i] = {1'b0, acc_q[i]} + (ACC_W+1)'(s1_err_q[i]);
      acc_d[i]   = acc_sum[i][ACC_W] ? {ACC_W{1'b1}} : acc_sum[i][ACC_W-1:0];
      mism_d[i]  = mism_q[i] + (WIN_LOG2+1)'(s1_mism_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (hs_cnt && (cnt_q == LastCnt)) state_d = StDrain;
      StDrain: begin
        if (drain_q) state_d = StDone;
        else         drain_d = 1'b1;
      end
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StRun: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= '0;
      s1_mism_q  <= '0;
      acc_q      <= '0;
      mism_q     <= '0;
    end else begin
      s1_valid_q <= hs_cnt;
      if (hs_cnt) begin
        s1_err_q  <= m_err;
        s1_mism_q <= m_mism;
      end
      if (clear) begin
        cnt_q      <= '0;
        s1_valid_q <= 1'b0;
        acc_q      <= '0;
        mism_q     <= '0;
      end else begin
        if (hs_cnt) cnt_q <= cnt_q + (WIN_LOG2+1)'(1);
        if (s1_valid_q) begin
          acc_q  <= acc_d;
          mism_q <= mism_d;
        end
      end
    end
  end

  assign err_approx  = acc_q[0];
  assign err_drum    = acc_q[1];
  assign err_foil    = acc_q[2];
  assign mism_approx = mism_q[0];
  assign mism_drum   = mism_q[1];
  assign mism_foil   = mism_q[2];

endmodule

// File: tb/tb_mult_err_accum.sv
// Bench for mult_err_accum: a 256-sample default window plus 4-sample windows on a 40-bit and a
// 24-bit accumulator build, with a cumulative-value scoreboard and hand-derived sample metrics.
module tb_mult_err_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_big, start_small, in_valid, exc;
  logic [31:0] result, res_a, res_d, res_f;

  logic        rdy_b, busy_b, done_b;
  logic [39:0] ea_b, ed_b, ef_b;
  logic [8:0]  ma_b, md_b, mf_b;

  logic        rdy_s, busy_s, done_s;
  logic [39:0] ea_s, ed_s, ef_s;
  logic [2:0]  ma_s, md_s, mf_s;

  logic        rdy_t, busy_t, done_t;
  logic [23:0] ea_t, ed_t, ef_t;
  logic [2:0]  ma_t, md_t, mf_t;

  mult_err_accum dut_big (
    .clk(clk), .rst_n(rst_n), .start(start_big), .in_valid(in_valid), .in_ready(rdy_b),
    .exc(exc), .result(result), .result_approx(res_a), .result_drum(res_d),
    .result_foil(res_f), .busy(busy_b), .done(done_b), .err_approx(ea_b), .err_drum(ed_b),
    .err_foil(ef_b), .mism_approx(ma_b), .mism_drum(md_b), .mism_foil(mf_b)
  );

  mult_err_accum #(.WIN_LOG2(2), .ACC_W(40)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start_small), .in_valid(in_valid), .in_ready(rdy_s),
    .exc(exc), .result(result), .result_approx(res_a), .result_drum(res_d),
    .result_foil(res_f), .busy(busy_s), .done(done_s), .err_approx(ea_s), .err_drum(ed_s),
    .err_foil(ef_s), .mism_approx(ma_s), .mism_drum(md_s), .mism_foil(mf_s)
  );

  mult_err_accum #(.WIN_LOG2(2), .ACC_W(24)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_small), .in_valid(in_valid), .in_ready(rdy_t),
    .exc(exc), .result(result), .result_approx(res_a), .result_drum(res_d),
    .result_foil(res_f), .busy(busy_t), .done(done_t), .err_approx(ea_t), .err_drum(ed_t),
    .err_foil(ef_t), .mism_approx(ma_t), .mism_drum(md_t), .mism_foil(mf_t)
  );

  logic [2:0][39:0] g40;
  logic [2:0][23:0] g24;
  logic [2:0][2:0]  gms, gmt;
  assign g40 = {ef_s, ed_s, ea_s};
  assign g24 = {ef_t, ed_t, ea_t};
  assign gms = {mf_s, md_s, ma_s};
  assign gmt = {mf_t, md_t, ma_t};

  typedef struct {
    logic        st, vld, ex;
    logic [31:0] r, a, d, f;
    logic [2:0][23:0] e;
    logic [2:0]  m;
  } vec_t;

  typedef struct {
    int               due;
    logic [2:0][39:0] e40;
    logic [2:0][23:0] e24;
    logic [2:0][2:0]  m;
  } sb_t;

  vec_t vt [20];
  sb_t  sbq [$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [2:0][39:0] m40;
  logic [2:0][23:0] m24;
  logic [2:0][2:0]  mm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic vld, input logic ex,
                              input logic [31:0] r, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] f, input logic [23:0] ea, input logic [23:0] ed,
                              input logic [23:0] ef, input logic [2:0] m);
    vec_t v;
    v.st = st; v.vld = vld; v.ex = ex;
    v.r = r; v.a = a; v.d = d; v.f = f;
    v.e = {ef, ed, ea};
    v.m = m;
    return v;
  endfunction

  function automatic logic [39:0] sat_add(input logic [39:0] acc, input logic [23:0] e,
                                          input logic [39:0] lim);
    logic [40:0] s;
    s = {1'b0, acc} + {17'b0, e};
    return (s > {1'b0, lim}) ? lim : s[39:0];
  endfunction

  // Monitor: compares each scoreboard entry on the cycle its sample should become visible.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("sb_due", 64'(e.due), 64'(cyc));
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("sb_err40[%0d]", j), 64'(g40[j]), 64'(e.e40[j]));
          chk($sformatf("sb_err24[%0d]", j), 64'(g24[j]), 64'(e.e24[j]));
          chk($sformatf("sb_mism40[%0d]", j), 64'(gms[j]), 64'(e.m[j]));
          chk($sformatf("sb_mism24[%0d]", j), 64'(gmt[j]), 64'(e.m[j]));
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    in_valid = v.vld; exc = v.ex;
    result = v.r; res_a = v.a; res_d = v.d; res_f = v.f;
  endtask

  task automatic run_window(input int lo, input int hi);
    m40 = '0; m24 = '0; mm = '0;
    @(negedge clk);
    start_small = 1'b1;
    @(posedge clk);
    #1;
    chk("start_busy", 64'(busy_s), 64'd1);
    chk("start_clear", 64'(|{g40, g24, gms, gmt}), 64'd0);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      start_small = vt[i].st;
      drive(vt[i]);
      chk("in_ready40", 64'(rdy_s), 64'd1);
      chk("in_ready24", 64'(rdy_t), 64'd1);
      if (vt[i].vld && !vt[i].ex) begin
        for (int j = 0; j < 3; j++) begin
          m40[j] = sat_add(m40[j], vt[i].e[j], 40'hFF_FFFF_FFFF);
          m24[j] = 24'(sat_add({16'b0, m24[j]}, vt[i].e[j], 40'h00_00FF_FFFF));
          mm[j]  = mm[j] + {2'b0, vt[i].m[j]};
        end
        sbq.push_back('{due: cyc + 2, e40: m40, e24: m24, m: mm});
      end
    end
    // start raised while draining must be ignored
    @(negedge clk);
    in_valid = 1'b0; exc = 1'b0; start_small = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_done", 64'(done_s), 64'd0);
    chk("drain_busy", 64'(busy_s), 64'd1);
    chk("drain_ready", 64'(rdy_s), 64'd0);
    @(negedge clk);
    start_small = 1'b0;
    @(posedge clk);
    #1;
    chk("done40", 64'(done_s), 64'd1);
    chk("done24", 64'(done_t), 64'd1);
    chk("done_busy", 64'(busy_s), 64'd0);
    chk("done_ready", 64'(rdy_s), 64'd0);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("final_err40[%0d]", j), 64'(g40[j]), 64'(m40[j]));
      chk($sformatf("final_err24[%0d]", j), 64'(g24[j]), 64'(m24[j]));
      chk($sformatf("final_mism[%0d]", j), 64'(gms[j]), 64'(mm[j]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Window 1: approx mantissa 1.0 vs reference 1.5
    for (int i = 0; i < 4; i++)
      vt[i] = mk(0, 1, 0, 32'h3FC00000, 32'h3F800000, 32'h3FC00000, 32'h3FC00000,
                 24'h400000, 24'h0, 24'h0, 3'b000);
    // Window 2: foil sign inverted
    for (int i = 4; i < 8; i++)
      vt[i] = mk(0, 1, 0, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'hBFC00000,
                 24'h0, 24'h0, 24'hFFFFFF, 3'b100);
    // Window 3: exc samples, valid gaps, and a start pulse while running
    vt[8]  = mk(0, 1, 0, 32'h40490FDB, 32'h40490000, 32'h40490FDB, 32'h40C90FDB,
                24'h000FDB, 24'h0, 24'hFFFFFF, 3'b100);
    vt[9]  = mk(0, 1, 1, 32'h3F800000, 32'hBF800000, 32'h7F800000, 32'h12345678,
                24'h0, 24'h0, 24'h0, 3'b000);
    vt[10] = mk(0, 0, 0, 32'h3F800000, 32'hBF800000, 32'h7F800000, 32'h12345678,
                24'h0, 24'h0, 24'h0, 3'b000);
    vt[11] = mk(1, 1, 0, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3F800000,
                24'h0, 24'h000001, 24'h0, 3'b000);
    vt[12] = mk(0, 1, 1, 32'h3F800000, 32'h00000000, 32'hFF800000, 32'hBF800000,
                24'h0, 24'h0, 24'h0, 3'b000);
    vt[13] = mk(0, 1, 0, 32'h3F7FFFFF, 32'h3F000000, 32'hBF7FFFFF, 32'h3F7FFFFF,
                24'h7FFFFF, 24'hFFFFFF, 24'h0, 3'b010);
    vt[14] = mk(0, 0, 1, 32'h3F800000, 32'hBF800000, 32'h7F800000, 32'h12345678,
                24'h0, 24'h0, 24'h0, 3'b000);
    vt[15] = mk(0, 1, 0, 32'hC2F60000, 32'hC2F70000, 32'hC2F50000, 32'hC2F60000,
                24'h010000, 24'h010000, 24'h0, 3'b000);
    // Window 4: every design mismatches on every sample
    for (int i = 16; i < 20; i++)
      vt[i] = mk(0, 1, 0, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000,
                 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 3'b111);

    rst_n = 1'b0; start_big = 1'b0; start_small = 1'b0; in_valid = 1'b0; exc = 1'b0;
    result = '0; res_a = '0; res_d = '0; res_f = '0;
    #2;
    chk("rst_state_big", 64'({rdy_b, busy_b, done_b}), 64'd0);
    chk("rst_state_small", 64'({rdy_s, busy_s, done_s, rdy_t, busy_t, done_t}), 64'd0);
    chk("rst_err_big", 64'(|{ea_b, ed_b, ef_b, ma_b, md_b, mf_b}), 64'd0);
    chk("rst_err_small", 64'(|{g40, g24, gms, gmt}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Default build: 256 identical samples
    @(negedge clk);
    start_big = 1'b1;
    @(negedge clk);
    start_big = 1'b0;
    in_valid = 1'b1; exc = 1'b0;
    result = 32'h3F800000; res_a = 32'h3F800000; res_d = 32'h3F800000; res_f = 32'h3F800000;
    for (int i = 0; i < 256; i++) begin
      chk("big_ready", 64'(rdy_b), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("big_drain_done", 64'(done_b), 64'd0);
    chk("big_drain_ready", 64'(rdy_b), 64'd0);
    chk("big_drain_busy", 64'(busy_b), 64'd1);
    @(posedge clk);
    #1;
    chk("big_done", 64'(done_b), 64'd1);
    chk("big_busy", 64'(busy_b), 64'd0);
    chk("big_err", 64'(|{ea_b, ed_b, ef_b}), 64'd0);
    chk("big_mism", 64'(|{ma_b, md_b, mf_b}), 64'd0);

    run_window(0, 3);
    run_window(4, 7);
    run_window(8, 15);
    run_window(16, 19);

    // Reset asserted mid-window discards partial results
    @(negedge clk);
    start_small = 1'b1;
    @(negedge clk);
    start_small = 1'b0;
    drive(vt[0]);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_err", 64'(ea_s), 64'h800000);
    chk("pre_rst_busy", 64'(busy_s), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_err", 64'(|{g40, g24, gms, gmt}), 64'd0);
    chk("mid_rst_state", 64'({rdy_s, busy_s, done_s, rdy_b, busy_b, done_b}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'({rdy_s, busy_s, done_s}), 64'd0);
    run_window(0, 3);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
